// File: rtl/pw_ram_arbiter_if.sv
// Requester and RAM-side signals of the password RAM arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface pw_ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 512
);
  logic              r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  ram_rdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output ram_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/pw_ram_arbiter.sv
// Round-robin arbiter for the single-port password/metadata RAM.
// One access in flight; read data is steered to the owner RD_LAT cycles after the enable.
module pw_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 512,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  pw_ram_arbiter_if.slave bus
);
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {IDLE, WR_DONE, RD_WAIT} state_t;

  logic [1:0]             req, we;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;

  assign req   = {bus.r1_req,   bus.r0_req};
  assign we    = {bus.r1_we,    bus.r0_we};
  assign addr  = {bus.r1_addr,  bus.r0_addr};
  assign wdata = {bus.r1_wdata, bus.r0_wdata};

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               last_q, last_d, owner_q, owner_d;
  logic               en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [1:0]         gnt_q, gnt_d, rv_q, rv_d;
  logic               sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    last_d  = last_q;
    owner_d = owner_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = '0;
    rv_d    = '0;
    // Under contention the requester that did not win last time goes first.
    sel     = (req == 2'b11) ? ~last_q : req[1];
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          en_d       = 1'b1;
          we_d       = we[sel];
          addr_d     = addr[sel];
          wdata_d    = wdata[sel];
          gnt_d[sel] = 1'b1;
          last_d     = sel;
          owner_d    = sel;
          lat_d      = '0;
          state_d    = we[sel] ? WR_DONE : RD_WAIT;
        end
      end
      WR_DONE: state_d = IDLE;
      RD_WAIT: begin
        // rvalid is registered, so it is scheduled one count early.
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          rv_d[owner_q] = 1'b1;
          lat_d         = '0;
          state_d       = IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_en    = en_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.r0_gnt    = gnt_q[0];
  assign bus.r1_gnt    = gnt_q[1];
  assign bus.r0_rvalid = rv_q[0];
  assign bus.r1_rvalid = rv_q[1];
  assign bus.r0_rdata  = bus.ram_rdata;
  assign bus.r1_rdata  = bus.ram_rdata;
endmodule

// File: doc/pw_ram_arbiter.md
Name: pw_ram_arbiter

Overview:
- Two-requester arbiter for the single-port 512-bit password/metadata RAM (12-bit address, 2-cycle read latency).
- Requester 0 is the UART command controller; requester 1 is the secondary engine (HID typing / wipe sequencer).
- Serialises accesses, applies round-robin fairness, drives the RAM enable/write/address/data, and returns read data with a valid strobe to the winner.
- One transaction in flight at a time.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 512, RAM word width.
- RD_LAT, 2, RAM read latency in cycles from the en cycle to valid ram_rdata; legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- r0_req  in  1  requester 0 access request; held until r0_gnt.
- r0_we  in  1  1 = write, 0 = read; held stable with req.
- r0_addr  in  ADDR_W  access address; held stable with req.
- r0_wdata  in  DATA_W  write data; held stable with req.
- r0_gnt  out  1  one-cycle pulse; the request is accepted.
- r0_rvalid  out  1  one-cycle pulse; r0_rdata is valid.
- r0_rdata  out  DATA_W  read data; equals ram_rdata, meaningful only while r0_rvalid.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: identical to the r0_* ports, for requester 1.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset values:
  - All outputs 0, except rX_rdata, which follows ram_rdata.
  - State IDLE; lat_cnt 0; last_grant = 1, so r0 wins the first contention.
- Registered outputs: ram_en, ram_we, ram_addr, ram_wdata, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid.
- Owner register: 1 bit, records the current grantee.
- State IDLE:
  - No req: hold all strobes low.
  - One req: select that requester.
  - Both req: select the requester != last_grant.
  - On selection (sampled at edge E), in the next cycle:
    - ram_en = 1, ram_we = rX_we, ram_addr = rX_addr, ram_wdata = rX_wdata;
    - rX_gnt = 1; last_grant and owner updated.
  - Next state: RD_WAIT if read, WR_DONE if write.
- State WR_DONE:
  - Lasts exactly 1 cycle; ram_en, ram_we and gnt return to 0; then IDLE.
  - Write occupancy is 2 cycles; maximum write throughput is 1 per 2 cycles.
- State RD_WAIT:
  - ram_en and gnt low; lat_cnt increments from 0.
  - owner_rvalid is asserted for exactly one cycle, in the cycle RD_LAT cycles after the ram_en cycle.
  - Return to IDLE in the same cycle as rvalid.
  - A new grant may appear in the cycle after rvalid.
  - Read occupancy is RD_LAT+1 cycles, i.e. 3 cycles at the default.
- Request rules:
  - Requests arriving while not in IDLE wait; they are never dropped by the arbiter.
  - A requester may deassert req before gnt (withdrawal); this is not an error and no access occurs.
  - Request fields are sampled only at the grant-decision edge; later changes are ignored.
- Exclusivity:
  - rvalid goes only to the owner. r0_rvalid and r1_rvalid are never both 1; r0_gnt and r1_gnt are never both 1.
- Starvation bound: with both requesters continuously requesting, grants alternate strictly r0, r1, r0, …
- Reset mid-operation:
  - All state clears immediately; an in-flight read produces no rvalid.
  - A write whose ram_en cycle completed before reset stands. Requesters must re-issue.
- Address and data pass through unmodified (no offset or width arithmetic).

Test Plan:
- Single read, r0: r0_req, we=0, addr=0x001; RAM word = 0xA5…A5.
  - Required: r0_gnt and ram_en=1 with ram_addr=0x001 one cycle later.
  - r0_rvalid exactly 2 cycles after ram_en, r0_rdata = 0xA5…A5.
  - r1_rvalid stays 0.
- Single write, r1: we=1, addr=0x00E, wdata=0x1234.
  - Required: one cycle of ram_en=ram_we=1 with ram_addr=0x00E and ram_wdata=0x1234, coincident with r1_gnt.
  - Next cycle ram_en=0; a read back of 0x00E returns 0x1234.
- Contention after reset: r0_req and r1_req both asserted continuously, reads.
  - Required grant order r0, r1, r0, r1; each grant 3 cycles apart; no overlapping rvalid.
- Blocking: r1 requests while an r0 read is in RD_WAIT.
  - Required: r1_gnt appears in the cycle after r0_rvalid, never earlier; no ram_en during RD_WAIT.
- Withdrawal: r1_req asserted 1 cycle during an r0 write, then dropped.
  - Required: no r1_gnt, no ram_en for r1, arbiter returns to IDLE.
- Reset mid-read: assert rst in the cycle after ram_en.
  - Required: all outputs 0 immediately, no rvalid; next r0 request is granted normally.
